// File: rtl/writeback_sequencer.sv
// Writer side of the integer register file's single write port: buffers ALU and
// load-unit writebacks in an in-order FIFO, drains one per cycle, and forwards in-flight values.
module writeback_sequencer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            phi2,
    input  logic            rst_n,

    input  logic            src0_valid,
    output logic            src0_ready,
    input  logic [4:0]      src0_addr,
    input  logic [XLEN-1:0] src0_value,

    input  logic            src1_valid,
    output logic            src1_ready,
    input  logic [4:0]      src1_addr,
    input  logic [XLEN-1:0] src1_value,

    output logic [4:0]      reg_wb_addr,
    output logic [XLEN-1:0] reg_wb_value,

    input  logic [4:0]      reg_read_addrs [0:1],
    output logic [1:0]      hazard,
    output logic [XLEN-1:0] fwd_value [0:1],

    output logic            idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] push_count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] slot1;

    logic [4:0]       entry_addr  [DEPTH];
    logic [XLEN-1:0]  entry_value [DEPTH];

    logic             push0;
    logic             push1;
    logic             pop;

    // Ready looks only at the registered count; the load unit wins the last free slot.
    assign free       = CNT_W'(DEPTH) - count;
    assign src1_ready = (free >= CNT_W'(1));
    assign src0_ready = (free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~src1_valid);

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push0 = src0_valid & src0_ready & (src0_addr != 5'd0);
    assign push1 = src1_valid & src1_ready & (src1_addr != 5'd0);
    assign pop   = (count != '0);

    assign push_count = CNT_W'(push0) + CNT_W'(push1);
    assign count_next = count - CNT_W'(pop) + push_count;
    assign slot1      = push0 ? PTR_W'(tail + PTR_W'(1)) : tail;

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            reg_wb_addr  <= 5'd0;
            reg_wb_value <= '0;
        end else begin
            count <= count_next;
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(push_count);
            if (pop) begin
                reg_wb_addr  <= entry_addr[head];
                reg_wb_value <= entry_value[head];
            end else begin
                reg_wb_addr  <= 5'd0;
                reg_wb_value <= '0;
            end
        end
    end

    // Storage needs no reset: an entry is only meaningful while it lies inside count.
    always_ff @(posedge phi2) begin
        if (push0) begin
            entry_addr[tail]  <= src0_addr;
            entry_value[tail] <= src0_value;
        end
        if (push1) begin
            entry_addr[slot1]  <= src1_addr;
            entry_value[slot1] <= src1_value;
        end
    end

    // Scan oldest to youngest so the last match (closest to tail) supplies the value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        hazard    = 2'b00;
        fwd_value = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (reg_read_addrs[i] != 5'd0) begin
                if (reg_wb_addr == reg_read_addrs[i]) begin
                    hazard[i]    = 1'b1;
                    fwd_value[i] = reg_wb_value;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    idx = PTR_W'(head + PTR_W'(k));
                    if ((CNT_W'(k) < count) && (entry_addr[idx] == reg_read_addrs[i])) begin
                        hazard[i]    = 1'b1;
                        fwd_value[i] = entry_value[idx];
                    end
                end
            end
        end
    end

    assign idle = (count == '0) & (reg_wb_addr == 5'd0);

endmodule
